mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU's memory-stage port and arbitrates every load and store.
- Decodes addresses to data memory (DM), Timer0, Timer1 and the interrupt generator (IG).
- Generates byte enables and detects address exceptions, which it returns to CPU CP0 in the same cycle.
- Registers load context so load data returned one cycle later (W stage) is selected and extended.

Parameters:
- DM_TOP, 32'h0000_2FFF, last valid DM byte address (DM base is 0).
- TC0_BASE, 32'h0000_7F00, Timer0 base; 3 words.
- TC1_BASE, 32'h0000_7F10, Timer1 base; 3 words.
- IG_BASE, 32'h0000_7F20, interrupt generator base; 1 word.

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous active-low reset (asserted when 0).
- addr in 32: CPU M-stage byte address.
- wdata in 32: CPU store data, unshifted.
- op in 4: access type: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9–15 are treated as none.
- exc_in in 5: upstream ExcCode: 0 Int, 12 Ov.
- req in 1: CP0 exception/interrupt request for the current M instruction.
- rdata out 32: extended load result, valid in the cycle after the load is in M.
- exc_out out 5: resolved ExcCode: 0 Int, 4 AdEL, 5 AdES, or exc_in passthrough.
- hw_int out 6: {3'b0, ig_irq, tc1_irq, tc0_irq}.
- dm_addr out 32: word-aligned address, {addr[31:2], 2'b00}.
- dm_byteen out 4: DM byte write enables.
- dm_wdata out 32: lane-shifted store data.
- dm_rdata in 32: DM synchronous read data, valid one cycle after dm_addr.
- tc0_addr out 2: Timer0 word offset.
- tc0_we out 1: Timer0 write enable.
- tc0_rdata in 32: Timer0 combinational read data.
- tc1_addr out 2: Timer1 word offset.
- tc1_we out 1: Timer1 write enable.
- tc1_rdata in 32: Timer1 combinational read data.
- tc0_irq in 1: Timer0 interrupt request.
- tc1_irq in 1: Timer1 interrupt request.
- ig_irq in 1: interrupt generator request.
- ig_byteen out 4: IG byte write enables; any nonzero value means acknowledge.

Behaviour:
- Decode (combinational): select DM, TC0, TC1, IG or none.
  - TC windows are base..base+11.
  - IG window is base..base+3.
- Width rules:
  - lw/sw require addr[1:0]==0.
  - lh/lhu/sh require addr[0]==0.
  - Byte accesses are unrestricted.
- exc_out priority, with op≠none:
  1. exc_in==12 → AdEL for loads, AdES for stores.
  2. exc_in≠0 → exc_in.
  3. Misaligned → AdEL/AdES.
  4. No region hit → AdEL/AdES.
  5. Half or byte access to TC0/TC1 → AdEL/AdES.
  6. Store to TC offset 8 (count register) → AdES.
  7. Otherwise 0.
- With op=none, exc_out = exc_in.
- Store lanes:
  - sw: byteen 4'b1111.
  - sh: 4'b0011 << addr[1:0]; dm_wdata = {2{wdata[15:0]}}.
  - sb: 4'b0001 << addr[1:0]; dm_wdata = {4{wdata[7:0]}}.
- Write gating: byteen and we are driven only when all of the following hold; otherwise all 0.
  - op is a store.
  - exc_out==0.
  - req==0.
  - The target region is selected.
- Load context register (lctx, updated every posedge):
  - Fields: op, addr[1:0], source (DM/TC0/TC1/IG/none).
  - Captured TC data: the selected tc*_rdata sampled at the posedge; 0 for IG.
  - If req==1 or exc_out≠0, lctx loads op=none.
- rdata (combinational from lctx):
  - Source raw word is dm_rdata for DM, otherwise the captured word.
  - lh: half chosen by addr[1], sign-extended. lhu: same half, zero-extended.
  - lb/lbu: byte chosen by addr[1:0], sign- or zero-extended.
  - lw: whole word.
  - op=none: 32'h0.
- Latency: exactly 1 cycle from load in M to valid rdata; no stalls, no handshake.
- Reset (reset==0, asynchronous):
  - lctx cleared; rdata=0.
  - All enables 0.
  - hw_int follows irq inputs (or 0 when the synchroniser below is enabled).
- Reset deassertion mid-stream: the first cycle behaves as op=none history.
- Simultaneous store with req=1: no write reaches any device; exc_out is still reported.
- Back-to-back load then store to the same address: the store writes in its M cycle and the load's rdata is unaffected.

Optional Feature:
- Macro: BRIDGE_IRQ_SYNC_EN.
- Defined: tc0_irq, tc1_irq and ig_irq each pass through one register stage before hw_int, adding 1 cycle of latency; the registers reset to 0.
- Undefined: hw_int is purely combinational from the irq inputs.

Test Plan:
- sw to 0x0000_1004, wdata 0xDEADBEEF → dm_byteen 1111, dm_addr 0x1004. Next cycle, lb at 0x1007 → rdata 0xFFFFFFDE; lbu → 0x000000DE.
- sh at 0x0000_0002, wdata 0x00001234 → dm_byteen 1100, dm_wdata 0x12341234, exc_out 0. sh at 0x0000_0003 → exc_out 5, byteen 0000.
- lw at 0x7F08 → tc0_addr 2, captured value returned next cycle. sw at 0x7F08 → exc_out 5, tc0_we 0. lh at 0x7F10 → exc_out 4.
- lw at 0x0000_3000 (unmapped) → exc_out 4. lw with exc_in=12 → exc_out 4. sb with exc_in=12 → exc_out 5.
- sw at 0x7F20 with req=1 → ig_byteen 0000, exc_out 0. Same store with req=0 → ig_byteen 1111.
- Pulse tc1_irq for 3 cycles → hw_int = 6'b000010 in the same cycles (shifted 1 cycle with BRIDGE_IRQ_SYNC_EN). Assert reset=0 mid-load → rdata = 0 immediately.

Source files
------------

// File: rtl/mem_io_bridge_if.sv
// CPU memory-stage port plus device-side buses of the load/store bridge.
interface mem_io_bridge_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  op;
    logic [4:0]  exc_in;
    logic        req;
    logic [31:0] rdata;
    logic [4:0]  exc_out;
    logic [5:0]  hw_int;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [1:0]  tc0_addr;
    logic        tc0_we;
    logic [31:0] tc0_rdata;
    logic [1:0]  tc1_addr;
    logic        tc1_we;
    logic [31:0] tc1_rdata;
    logic        tc0_irq;
    logic        tc1_irq;
    logic        ig_irq;
    logic [3:0]  ig_byteen;

    modport slave (
        input  addr, wdata, op, exc_in, req,
        input  dm_rdata, tc0_rdata, tc1_rdata,
        input  tc0_irq, tc1_irq, ig_irq,
        output rdata, exc_out, hw_int,
        output dm_addr, dm_byteen, dm_wdata,
        output tc0_addr, tc0_we, tc1_addr, tc1_we,
        output ig_byteen
    );

    modport master (
        output addr, wdata, op, exc_in, req,
        output dm_rdata, tc0_rdata, tc1_rdata,
        output tc0_irq, tc1_irq, ig_irq,
        input  rdata, exc_out, hw_int,
        input  dm_addr, dm_byteen, dm_wdata,
        input  tc0_addr, tc0_we, tc1_addr, tc1_we,
        input  ig_byteen
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Load/store bridge: decode, byte lanes, address exceptions, W-stage load extend.
// Optional BRIDGE_IRQ_SYNC_EN registers the irq inputs before hw_int.
module mem_io_bridge #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
    input  logic           clk,
    input  logic           reset,
    mem_io_bridge_if.slave bus
);
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_DM,
        SRC_TC0,
        SRC_TC1,
        SRC_IG
    } src_e;

    src_e        src;
    logic        is_ld;
    logic        is_st;
    logic        sz_w;
    logic        sz_h;
    logic        misal;
    logic        is_tc;
    logic        wr_ok;
    logic [4:0]  bad;
    logic [4:0]  exc;
    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        src = SRC_NONE;
        if (bus.addr <= DM_TOP)
            src = SRC_DM;
        else if (bus.addr >= TC0_BASE &&
                 bus.addr <= TC0_BASE + 32'd11)
            src = SRC_TC0;
        else if (bus.addr >= TC1_BASE &&
                 bus.addr <= TC1_BASE + 32'd11)
            src = SRC_TC1;
        else if (bus.addr >= IG_BASE &&
                 bus.addr <= IG_BASE + 32'd3)
            src = SRC_IG;
    end

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sz_w  = 1'b0;
        sz_h  = 1'b0;
        case (bus.op)
            OP_LW:         begin is_ld = 1'b1; sz_w = 1'b1; end
            OP_LH, OP_LHU: begin is_ld = 1'b1; sz_h = 1'b1; end
            OP_LB, OP_LBU: is_ld = 1'b1;
            OP_SW:         begin is_st = 1'b1; sz_w = 1'b1; end
            OP_SH:         begin is_st = 1'b1; sz_h = 1'b1; end
            OP_SB:         is_st = 1'b1;
            default:       ;
        endcase
    end

    assign misal = (sz_w && bus.addr[1:0] != 2'b00) ||
                   (sz_h && bus.addr[0]);
    assign is_tc = (src == SRC_TC0) || (src == SRC_TC1);
    assign bad   = is_st ? EXC_ADES : EXC_ADEL;

    // Timer bases are 16-byte aligned, so addr[3:2] is the word offset.
    always_comb begin
        exc = bus.exc_in;
        if (is_ld || is_st) begin
            if (bus.exc_in == EXC_OV)
                exc = bad;
            else if (bus.exc_in != EXC_INT)
                exc = bus.exc_in;
            else if (misal)
                exc = bad;
            else if (src == SRC_NONE)
                exc = bad;
            else if (is_tc && !sz_w)
                exc = bad;
            else if (is_st && is_tc && bus.addr[3:2] == 2'd2)
                exc = EXC_ADES;
            else
                exc = EXC_INT;
        end
    end

    always_comb begin
        be = 4'b0000;
        wd = bus.wdata;
        case (bus.op)
            OP_SW: be = 4'b1111;
            OP_SH: begin
                be = 4'b0011 << bus.addr[1:0];
                wd = {2{bus.wdata[15:0]}};
            end
            OP_SB: begin
                be = 4'b0001 << bus.addr[1:0];
                wd = {4{bus.wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign wr_ok = is_st && (exc == EXC_INT) &&
                   !bus.req && reset;

    assign bus.exc_out   = exc;
    assign bus.dm_addr   = {bus.addr[31:2], 2'b00};
    assign bus.dm_wdata  = wd;
    assign bus.dm_byteen = (wr_ok && src == SRC_DM) ? be : 4'b0000;
    assign bus.ig_byteen = (wr_ok && src == SRC_IG) ? be : 4'b0000;
    assign bus.tc0_addr  = bus.addr[3:2];
    assign bus.tc1_addr  = bus.addr[3:2];
    assign bus.tc0_we    = wr_ok && (src == SRC_TC0);
    assign bus.tc1_we    = wr_ok && (src == SRC_TC1);

    logic [3:0]  op_q,   op_d;
    logic [1:0]  ofs_q,  ofs_d;
    src_e        src_q,  src_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        op_d   = OP_NONE;
        ofs_d  = bus.addr[1:0];
        src_d  = src;
        word_d = 32'h0;
        if (is_ld && exc == EXC_INT && !bus.req)
            op_d = bus.op;
        case (src)
            SRC_TC0: word_d = bus.tc0_rdata;
            SRC_TC1: word_d = bus.tc1_rdata;
            default: word_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_NONE;
            ofs_q  <= 2'b00;
            src_q  <= SRC_NONE;
            word_q <= 32'h0;
        end else begin
            op_q   <= op_d;
            ofs_q  <= ofs_d;
            src_q  <= src_d;
            word_q <= word_d;
        end
    end

    logic [31:0] raw;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] rd;

    assign raw    = (src_q == SRC_DM) ? bus.dm_rdata : word_q;
    assign half_v = ofs_q[1] ? raw[31:16] : raw[15:0];
    assign byte_v = raw[{ofs_q, 3'b000} +: 8];

    always_comb begin
        rd = 32'h0;
        case (op_q)
            OP_LW:   rd = raw;
            OP_LH:   rd = {{16{half_v[15]}}, half_v};
            OP_LHU:  rd = {16'h0, half_v};
            OP_LB:   rd = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  rd = {24'h0, byte_v};
            default: rd = 32'h0;
        endcase
    end

    assign bus.rdata = rd;

`ifdef BRIDGE_IRQ_SYNC_EN
    logic [2:0] irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq_q <= 3'b000;
        else
            irq_q <= {bus.ig_irq, bus.tc1_irq, bus.tc0_irq};
    end

    assign bus.hw_int = {3'b000, irq_q};
`else
    assign bus.hw_int = {3'b000, bus.ig_irq,
                         bus.tc1_irq, bus.tc0_irq};
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios plus random traffic
// checked against an arithmetic model of the address map and lanes.
module tb_mem_io_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_io_bridge_if bus ();

    mem_io_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] dm_mem  [0:3071];
    logic [31:0] ref_mem [0:3071];

    always @(posedge clk) begin
        if (bus.dm_addr <= 32'h2FFF) begin
            bus.dm_rdata <= dm_mem[bus.dm_addr[13:2]];
            for (int b = 0; b < 4; b++)
                if (bus.dm_byteen[b])
                    dm_mem[bus.dm_addr[13:2]][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
        end else begin
            bus.dm_rdata <= 32'hBAD0_BAD0;
        end
    end

    logic [31:0] exp_rdata, pend_rdata;
    logic [4:0]  exp_exc;
    logic [3:0]  exp_dm_be, exp_ig_be;
    logic        exp_tc0_we, exp_tc1_we;
    logic [31:0] exp_dm_wdata, exp_dm_addr;

    function automatic int acc_size(input logic [3:0] o);
        case (o)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    // 0 none, 1 DM, 2 TC0, 3 TC1, 4 IG
    function automatic int region(input logic [31:0] a);
        if (a <= 32'h2FFF) return 1;
        if (a >= 32'h7F00 && a < 32'h7F0C) return 2;
        if (a >= 32'h7F10 && a < 32'h7F1C) return 3;
        if (a >= 32'h7F20 && a < 32'h7F24) return 4;
        return 0;
    endfunction

    function automatic logic [4:0] ref_exc(input logic [3:0] o,
                                           input logic [31:0] a,
                                           input logic [4:0] e);
        int sz, rg;
        bit st;
        logic [4:0] bad;
        logic [31:0] base;
        sz = acc_size(o);
        st = (o >= 4'd6 && o <= 4'd8);
        bad = st ? 5'd5 : 5'd4;
        if (sz == 0) return e;
        if (e == 5'd12) return bad;
        if (e != 5'd0) return e;
        if (a % sz != 0) return bad;
        rg = region(a);
        if (rg == 0) return bad;
        if ((rg == 2 || rg == 3) && sz != 4) return bad;
        base = (rg == 2) ? 32'h7F00 : 32'h7F10;
        if (st && (rg == 2 || rg == 3) && a - base == 32'd8) return 5'd5;
        return 5'd0;
    endfunction

    function automatic logic [31:0] extract(input logic [3:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] raw);
        logic [31:0] b, h;
        b = (raw >> (8 * a[1:0])) & 32'hFF;
        h = (raw >> (16 * a[1])) & 32'hFFFF;
        case (o)
            4'd1:    return raw;
            4'd2:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            4'd3:    return h;
            4'd4:    return (b >= 32'd128) ? b - 32'd256 : b;
            4'd5:    return b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic apply(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] e,
                         input logic r, input logic [31:0] t0,
                         input logic [31:0] t1);
        int sz, rg;
        logic [3:0] mask;
        logic [31:0] lane, raw;
        bit st;
        @(posedge clk);
        exp_rdata = reset ? pend_rdata : 32'h0;
        #1;
        bus.op = o; bus.addr = a; bus.wdata = w;
        bus.exc_in = e; bus.req = r;
        bus.tc0_rdata = t0; bus.tc1_rdata = t1;
        sz = acc_size(o);
        rg = region(a);
        st = (o >= 4'd6 && o <= 4'd8);
        exp_exc = ref_exc(o, a, e);
        exp_dm_addr = a & 32'hFFFF_FFFC;
        lane = w;
        if (sz == 2) lane = {16'h0, w[15:0]} * 32'h0001_0001;
        if (sz == 1) lane = {24'h0, w[7:0]} * 32'h0101_0101;
        exp_dm_wdata = lane;
        mask = 4'h0;
        if (st && exp_exc == 5'd0 && !r && reset)
            mask = 4'(((1 << sz) - 1) << a[1:0]);
        exp_dm_be = (rg == 1) ? mask : 4'h0;
        exp_ig_be = (rg == 4) ? mask : 4'h0;
        exp_tc0_we = (rg == 2) && (mask != 4'h0);
        exp_tc1_we = (rg == 3) && (mask != 4'h0);
        if (exp_dm_be != 4'h0)
            for (int b = 0; b < 4; b++)
                if (mask[b]) ref_mem[a[13:2]][8*b +: 8] = lane[8*b +: 8];
        pend_rdata = 32'h0;
        if (o >= 4'd1 && o <= 4'd5 && exp_exc == 5'd0 && !r) begin
            raw = (rg == 1) ? ref_mem[a[13:2]] :
                  (rg == 2) ? t0 : (rg == 3) ? t1 : 32'h0;
            pend_rdata = extract(o, a, raw);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(4'd6, 32'h1000, 32'h1111_1111, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.dm_byteen !== 4'h0) begin miscompares++; $display("FAIL rst_byteen got %b want 0000", bus.dm_byteen); end
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
        apply(4'd6, 32'h7F04, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.tc0_we !== 1'b0) begin miscompares++; $display("FAIL rst_tc0_we got %b want 0", bus.tc0_we); end
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_release_rdata got %h want 0", bus.rdata); end
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_first_rdata got %h want 0", bus.rdata); end
    endtask

    task automatic test_dm();
        apply(4'd6, 32'h1004, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.dm_byteen !== 4'b1111) begin miscompares++; $display("FAIL sw_byteen got %b want 1111", bus.dm_byteen); end
        vectors++; if (bus.dm_addr !== 32'h1004) begin miscompares++; $display("FAIL sw_addr got %h want 1004", bus.dm_addr); end
        vectors++; if (bus.dm_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_wdata got %h want deadbeef", bus.dm_wdata); end
        apply(4'd4, 32'h1007, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.exc_out !== 5'd0) begin miscompares++; $display("FAIL lb_exc got %0d want 0", bus.exc_out); end
        apply(4'd5, 32'h1007, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'hFFFF_FFDE) begin miscompares++; $display("FAIL lb_rdata got %h want ffffffde", bus.rdata); end
        apply(4'd2, 32'h1006, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0000_00DE) begin miscompares++; $display("FAIL lbu_rdata got %h want 000000de", bus.rdata); end
        apply(4'd3, 32'h1004, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'hFFFF_DEAD) begin miscompares++; $display("FAIL lh_rdata got %h want ffffdead", bus.rdata); end
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0000_BEEF) begin miscompares++; $display("FAIL lhu_rdata got %h want 0000beef", bus.rdata); end
    endtask

    task automatic test_half_byte();
        apply(4'd7, 32'h0002, 32'h0000_1234, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.dm_byteen !== 4'b1100) begin miscompares++; $display("FAIL sh_byteen got %b want 1100", bus.dm_byteen); end
        vectors++; if (bus.dm_wdata !== 32'h1234_1234) begin miscompares++; $display("FAIL sh_wdata got %h want 12341234", bus.dm_wdata); end
        vectors++; if (bus.exc_out !== 5'd0) begin miscompares++; $display("FAIL sh_exc got %0d want 0", bus.exc_out); end
        apply(4'd7, 32'h0003, 32'h0000_5678, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.exc_out !== 5'd5) begin miscompares++; $display("FAIL sh_mis_exc got %0d want 5", bus.exc_out); end
        vectors++; if (bus.dm_byteen !== 4'b0000) begin miscompares++; $display("FAIL sh_mis_byteen got %b want 0000", bus.dm_byteen); end
        apply(4'd8, 32'h0003, 32'h0000_00AB, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.dm_byteen !== 4'b1000) begin miscompares++; $display("FAIL sb_byteen got %b want 1000", bus.dm_byteen); end
        vectors++; if (bus.dm_wdata !== 32'hABAB_ABAB) begin miscompares++; $display("FAIL sb_wdata got %h want abababab", bus.dm_wdata); end
        apply(4'd1, 32'h0000, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'hAB34_0000) begin miscompares++; $display("FAIL lanes_rdata got %h want ab340000", bus.rdata); end
    endtask

    task automatic test_timer();
        apply(4'd1, 32'h7F08, 32'h0, 5'd0, 1'b0, 32'hA5A5_1234, 32'h0);
        vectors++; if (bus.tc0_addr !== 2'd2) begin miscompares++; $display("FAIL tc0_addr got %0d want 2", bus.tc0_addr); end
        vectors++; if (bus.exc_out !== 5'd0) begin miscompares++; $display("FAIL tc0_lw_exc got %0d want 0", bus.exc_out); end
        apply(4'd6, 32'h7F08, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'hA5A5_1234) begin miscompares++; $display("FAIL tc0_rdata got %h want a5a51234", bus.rdata); end
        vectors++; if (bus.exc_out !== 5'd5) begin miscompares++; $display("FAIL tc0_count_exc got %0d want 5", bus.exc_out); end
        vectors++; if (bus.tc0_we !== 1'b0) begin miscompares++; $display("FAIL tc0_count_we got %b want 0", bus.tc0_we); end
        apply(4'd2, 32'h7F10, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.exc_out !== 5'd4) begin miscompares++; $display("FAIL tc1_lh_exc got %0d want 4", bus.exc_out); end
        apply(4'd6, 32'h7F04, 32'h5, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.tc0_we !== 1'b1 || bus.tc0_addr !== 2'd1) begin miscompares++; $display("FAIL tc0_sw got we=%b addr=%0d want we=1 addr=1", bus.tc0_we, bus.tc0_addr); end
        apply(4'd6, 32'h7F14, 32'h7, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.tc1_we !== 1'b1 || bus.tc0_we !== 1'b0) begin miscompares++; $display("FAIL tc1_sw got tc1_we=%b tc0_we=%b want 1 0", bus.tc1_we, bus.tc0_we); end
        apply(4'd1, 32'h7F18, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0BAD_CAFE);
        vectors++; if (bus.exc_out !== 5'd0) begin miscompares++; $display("FAIL tc1_lw_exc got %0d want 0", bus.exc_out); end
        apply(4'd1, 32'h7F0C, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.exc_out !== 5'd4) begin miscompares++; $display("FAIL tc0_edge_exc got %0d want 4", bus.exc_out); end
        vectors++; if (bus.rdata !== 32'h0BAD_CAFE) begin miscompares++; $display("FAIL tc1_rdata got %h want 0badcafe", bus.rdata); end
    endtask

    task automatic test_exceptions();
        logic [3:0] ops [9] = '{4'd1, 4'd1, 4'd1, 4'd8, 4'd1, 4'd1, 4'd0, 4'd9, 4'd6};
        logic [31:0] adr [9] = '{32'h3000, 32'h2FFC, 32'h1000, 32'h1001, 32'h1002,
                                 32'h1002, 32'h1003, 32'h1003, 32'h7F21};
        logic [4:0] ein [9] = '{5'd0, 5'd0, 5'd12, 5'd12, 5'd8, 5'd0, 5'd12, 5'd0, 5'd0};
        logic [4:0] want [9] = '{5'd4, 5'd0, 5'd4, 5'd5, 5'd8, 5'd4, 5'd12, 5'd0, 5'd5};
        for (int i = 0; i < 9; i++) begin
            apply(ops[i], adr[i], 32'hFFFF_FFFF, ein[i], 1'b0, 32'h0, 32'h0);
            vectors++; if (bus.exc_out !== want[i]) begin miscompares++; $display("FAIL exc_case%0d got %0d want %0d", i, bus.exc_out, want[i]); end
            vectors++; if (bus.dm_byteen !== 4'h0 || bus.ig_byteen !== 4'h0) begin miscompares++; $display("FAIL exc_nowrite%0d got dm=%b ig=%b want 0000", i, bus.dm_byteen, bus.ig_byteen); end
        end
    endtask

    task automatic test_ig_req();
        apply(4'd6, 32'h7F20, 32'h1, 5'd0, 1'b1, 32'h0, 32'h0);
        vectors++; if (bus.ig_byteen !== 4'b0000 || bus.exc_out !== 5'd0) begin miscompares++; $display("FAIL ig_req got be=%b exc=%0d want 0000 0", bus.ig_byteen, bus.exc_out); end
        apply(4'd6, 32'h7F20, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.ig_byteen !== 4'b1111) begin miscompares++; $display("FAIL ig_sw got %b want 1111", bus.ig_byteen); end
        apply(4'd8, 32'h7F22, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.ig_byteen !== 4'b0100) begin miscompares++; $display("FAIL ig_sb got %b want 0100", bus.ig_byteen); end
        apply(4'd1, 32'h7F20, 32'h0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply(4'd1, 32'h1004, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL ig_rdata got %h want 0", bus.rdata); end
        apply(4'd6, 32'h1004, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL req_load_rdata got %h want 0", bus.rdata); end
        vectors++; if (bus.dm_byteen !== 4'h0) begin miscompares++; $display("FAIL req_store_be got %b want 0000", bus.dm_byteen); end
    endtask

    task automatic test_back_to_back();
        apply(4'd1, 32'h1004, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        apply(4'd6, 32'h1004, 32'h0102_0304, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL b2b_load got %h want deadbeef", bus.rdata); end
        vectors++; if (bus.dm_byteen !== 4'b1111) begin miscompares++; $display("FAIL b2b_store got %b want 1111", bus.dm_byteen); end
        apply(4'd1, 32'h1004, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0102_0304) begin miscompares++; $display("FAIL b2b_after got %h want 01020304", bus.rdata); end
    endtask

    task automatic test_reset_mid_load();
        apply(4'd1, 32'h1004, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0102_0304) begin miscompares++; $display("FAIL mid_pre got %h want 01020304", bus.rdata); end
        #1 reset = 1'b0;
        #1;
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst got %h want 0", bus.rdata); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mid_release got %h want 0", bus.rdata); end
        apply(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mid_first got %h want 0", bus.rdata); end
    endtask

    task automatic test_irq();
        logic [7:0] pat;
        logic prev, cur, exp_b;
        pat = 8'b0001_1100;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 bus.tc1_irq = pat[i];
            cur = pat[i];
            @(negedge clk);
`ifdef BRIDGE_IRQ_SYNC_EN
            exp_b = prev;
`else
            exp_b = cur;
`endif
            vectors++; if (bus.hw_int !== {4'b0000, exp_b, 1'b0}) begin miscompares++; $display("FAIL irq_tc1 cyc%0d got %b want %b", i, bus.hw_int, {4'b0000, exp_b, 1'b0}); end
            prev = cur;
        end
        @(posedge clk);
        #1;
        bus.tc0_irq = 1'b1;
        bus.ig_irq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.hw_int !== 6'b000101) begin miscompares++; $display("FAIL irq_all got %b want 000101", bus.hw_int); end
        bus.tc0_irq = 1'b0;
        bus.ig_irq = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [31:0] a;
        logic [4:0] e;
        logic r;
        for (int i = 0; i < 400; i++) begin
            o = 4'($urandom_range(0, 10));
            case ($urandom_range(0, 5))
                0: a = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                1: a = 32'h2FF8 + $urandom_range(0, 15);
                2: a = 32'h7F00 + $urandom_range(0, 15);
                3: a = 32'h7F10 + $urandom_range(0, 15);
                4: a = 32'h7F20 + $urandom_range(0, 7);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0: e = 5'd12;
                1: e = 5'd8;
                default: e = 5'd0;
            endcase
            r = ($urandom_range(0, 9) == 0);
            apply(o, a, $urandom, e, r, $urandom, $urandom);
            vectors++; if (bus.exc_out !== exp_exc) begin miscompares++; $display("FAIL rnd_exc #%0d op=%0d a=%h got %0d want %0d", i, o, a, bus.exc_out, exp_exc); end
            vectors++; if (bus.dm_byteen !== exp_dm_be) begin miscompares++; $display("FAIL rnd_dm_be #%0d got %b want %b", i, bus.dm_byteen, exp_dm_be); end
            vectors++; if (bus.ig_byteen !== exp_ig_be) begin miscompares++; $display("FAIL rnd_ig_be #%0d got %b want %b", i, bus.ig_byteen, exp_ig_be); end
            vectors++; if (bus.tc0_we !== exp_tc0_we || bus.tc1_we !== exp_tc1_we) begin miscompares++; $display("FAIL rnd_tc_we #%0d got %b%b want %b%b", i, bus.tc0_we, bus.tc1_we, exp_tc0_we, exp_tc1_we); end
            vectors++; if (bus.dm_addr !== exp_dm_addr) begin miscompares++; $display("FAIL rnd_dm_addr #%0d got %h want %h", i, bus.dm_addr, exp_dm_addr); end
            vectors++; if (bus.rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_rdata #%0d got %h want %h", i, bus.rdata, exp_rdata); end
            if (exp_dm_be != 4'h0) begin
                vectors++; if (bus.dm_wdata !== exp_dm_wdata) begin miscompares++; $display("FAIL rnd_wdata #%0d got %h want %h", i, bus.dm_wdata, exp_dm_wdata); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3072; i++) begin
            dm_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        pend_rdata = 32'h0;
        bus.op = 4'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
        bus.exc_in = 5'd0; bus.req = 1'b0;
        bus.tc0_rdata = 32'h0; bus.tc1_rdata = 32'h0;
        bus.tc0_irq = 1'b0; bus.tc1_irq = 1'b0; bus.ig_irq = 1'b0;
        test_reset();
        test_dm();
        test_half_byte();
        test_timer();
        test_exceptions();
        test_ig_req();
        test_back_to_back();
        test_reset_mid_load();
        test_irq();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
